// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter family: mode and direction encodings
// plus the iterative shifter's state encoding.
package shifter_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter; one step of the iterative shifter.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out
);

  // Arithmetic left is the same as logical left; the reserved mode rotates.
  always_comb begin
    out = in;
    case (mode)
      MODE_LOGIC: out = (dir == DIR_RIGHT) ? {1'b0, in[WIDTH-1:1]}
                                           : {in[WIDTH-2:0], 1'b0};
      MODE_ARITH: out = (dir == DIR_RIGHT) ? {in[WIDTH-1], in[WIDTH-1:1]}
                                           : {in[WIDTH-2:0], 1'b0};
      MODE_ROT,
      MODE_RSVD:  out = (dir == DIR_RIGHT) ? {in[0], in[WIDTH-1:1]}
                                           : {in[WIDTH-2:0], in[WIDTH-1]};
      default:    out = in;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: moves the word one bit per clock and pulses done
// when the result in out is final.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shift,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_t           state;
  state_t           next_state;
  logic [SHW-1:0]   cnt;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .in   (out),
    .dir  (dir_q),
    .mode (mode_q),
    .out  (step_out)
  );

  assign busy = (state != IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operands are captured only on acceptance, so the input ports are free
  // to change while an operation is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      out    <= '0;
      cnt    <= '0;
      dir_q  <= DIR_LEFT;
      mode_q <= MODE_LOGIC;
      done   <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            out    <= in;
            cnt    <= shift;
            dir_q  <= dir;
            mode_q <= mode;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            out <= step_out;
            cnt <= cnt - 1'b1;
          end else begin
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter against an arithmetic reference.
module tb_iterative_shifter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] in;
  logic [2:0] shift;
  logic       dir;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic [7:0] out;

  int checks;
  int errors;

  iterative_shifter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in),
    .shift (shift),
    .dir   (dir),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from whole-word arithmetic on the requested amount.
  function automatic logic [7:0] ref_shift(input logic [7:0] a, input int sh,
                                           input logic d, input logic [1:0] m);
    logic [15:0] w;
    logic [15:0] r;
    logic [7:0]  t;
    w = {a, a};
    if (m[1]) begin
      if (d) begin
        r = w >> sh;
        t = r[7:0];
      end else begin
        r = w << sh;
        t = r[15:8];
      end
    end else if (!d) begin
      t = a << sh;
    end else if (m == 2'b01) begin
      t = $signed(a) >>> sh;
    end else begin
      t = a >> sh;
    end
    return t;
  endfunction

  // Issues one request and observes the 20 cycles after acceptance.
  // Cycle 1 is the cycle directly after the accept edge.
  task automatic do_op(input logic [7:0] a, input logic [2:0] sh, input logic d,
                       input logic [1:0] m, output logic [7:0] res, output int lat,
                       output int ndone, output int nbusy, output logic [7:0] after);
    in = a; shift = sh; dir = d; mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in = 8'($urandom); shift = 3'($urandom); dir = 1'($urandom); mode = 2'($urandom);
    res = 'x; lat = -1; ndone = 0; nbusy = 0; after = 'x;
    for (int c = 1; c <= 20; c++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          res = out;
        end
      end
      if (lat > 0 && c == lat + 2) after = out;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in = 8'h00; shift = 3'd0; dir = 1'b0; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: out=%h busy=%b done=%b, required out=00 busy=0 done=0",
               out, busy, done);
    end
    in = 8'hFF; shift = 3'd5;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_quiet: out=%h busy=%b done=%b, required out=00 busy=0 done=0",
                 out, busy, done);
      end
    end
  endtask

  task automatic test_rotate_left();
    logic [7:0] res, after;
    int lat, nd, nb;
    do_op(8'h56, 3'd3, 1'b0, 2'b10, res, lat, nd, nb, after);
    checks++;
    if (res !== 8'hB2 || lat != 5 || nd != 1 || nb != 5) begin
      errors++;
      $display("[TB] FAIL rotate_left: out=%h lat=%0d dones=%0d busy=%0d, required B2 5 1 5",
               res, lat, nd, nb);
    end
    checks++;
    if (after !== 8'hB2) begin
      errors++;
      $display("[TB] FAIL rotate_hold: out=%h, required B2", after);
    end
  endtask

  task automatic test_right_shifts();
    logic [7:0] res, after;
    int lat, nd, nb;
    do_op(8'h56, 3'd2, 1'b1, 2'b00, res, lat, nd, nb, after);
    checks++;
    if (res !== 8'h15 || lat != 4 || nd != 1) begin
      errors++;
      $display("[TB] FAIL logical_right: out=%h lat=%0d dones=%0d, required 15 4 1", res, lat, nd);
    end
    do_op(8'hA6, 3'd3, 1'b1, 2'b01, res, lat, nd, nb, after);
    checks++;
    if (res !== 8'hF4 || lat != 5 || nd != 1) begin
      errors++;
      $display("[TB] FAIL arith_right: out=%h lat=%0d dones=%0d, required F4 5 1", res, lat, nd);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] res, after;
    int lat, nd, nb;
    for (int m = 0; m < 4; m++) begin
      do_op(8'h56, 3'd0, 1'($urandom), 2'(m), res, lat, nd, nb, after);
      checks++;
      if (res !== 8'h56 || lat != 2 || nd != 1 || nb != 2) begin
        errors++;
        $display("[TB] FAIL shift_zero mode=%0d: out=%h lat=%0d dones=%0d busy=%0d, required 56 2 1 2",
                 m, res, lat, nd, nb);
      end
    end
    do_op(8'h56, 3'd7, 1'b1, 2'b10, res, lat, nd, nb, after);
    checks++;
    if (res !== 8'hAC || lat != 9 || nd != 1 || nb != 9) begin
      errors++;
      $display("[TB] FAIL shift_max: out=%h lat=%0d dones=%0d busy=%0d, required AC 9 1 9",
               res, lat, nd, nb);
    end
  endtask

  // start held high with fresh operands every cycle; only IDLE accepts.
  task automatic test_back_to_back();
    logic [7:0] a_in [0:40];
    logic [2:0] a_sh [0:40];
    logic       a_d  [0:40];
    logic [1:0] a_m  [0:40];
    logic [7:0] exp1, exp2;
    int e2, t1, t2, nd, bad;
    a_in[0] = 8'($urandom); a_sh[0] = 3'($urandom); a_d[0] = 1'($urandom); a_m[0] = 2'($urandom);
    e2 = a_sh[0] + 3;
    in = a_in[0]; shift = a_sh[0]; dir = a_d[0]; mode = a_m[0]; start = 1'b1;
    nd = 0; bad = 0; exp2 = 'x;
    for (int t = 0; t <= 34; t++) begin
      @(posedge clk); #1;
      if (t == e2) begin
        exp2 = ref_shift(a_in[e2], a_sh[e2], a_d[e2], a_m[e2]);
        t2 = e2 + a_sh[e2] + 1;
      end
      if (done) begin
        nd++;
        if (t == a_sh[0] + 1) begin
          exp1 = ref_shift(a_in[0], a_sh[0], a_d[0], a_m[0]);
          checks++;
          if (out !== exp1) begin
            errors++;
            $display("[TB] FAIL b2b_first: out=%h, required %h", out, exp1);
          end
        end else if (t > e2 && t == t2) begin
          checks++;
          if (out !== exp2) begin
            errors++;
            $display("[TB] FAIL b2b_second: out=%h, required %h", out, exp2);
          end
        end else begin
          bad++;
        end
      end
      if (t + 1 <= 40) begin
        a_in[t+1] = 8'($urandom); a_sh[t+1] = 3'($urandom);
        a_d[t+1] = 1'($urandom); a_m[t+1] = 2'($urandom);
        in = a_in[t+1]; shift = a_sh[t+1]; dir = a_d[t+1]; mode = a_m[t+1];
      end
      start = (t + 1 <= e2);
    end
    t1 = nd;
    checks++;
    if (t1 != 2 || bad != 0) begin
      errors++;
      $display("[TB] FAIL b2b_done_count: dones=%0d misplaced=%0d, required 2 0", t1, bad);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int nd;
    in = 8'h56; shift = 3'd7; dir = 1'b0; mode = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: out=%h busy=%b done=%b, required 00 0 0",
               out, busy, done);
    end
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      if (done || busy) nd++;
      @(posedge clk); #1;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_quiet: active cycles=%0d, required 0", nd);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] res, after, a, exp;
    int lat, nd, nb;
    for (int s = 0; s < 8; s++)
      for (int m = 0; m < 4; m++)
        for (int d = 0; d < 2; d++) begin
          a = 8'($urandom);
          exp = ref_shift(a, s, 1'(d), 2'(m));
          do_op(a, 3'(s), 1'(d), 2'(m), res, lat, nd, nb, after);
          checks++;
          if (res !== exp || lat != s + 2 || nd != 1 || after !== exp) begin
            errors++;
            $display("[TB] FAIL sweep in=%h sh=%0d dir=%0d mode=%0d: out=%h lat=%0d dones=%0d hold=%h, required %h %0d 1 %h",
                     a, s, d, m, res, lat, nd, after, exp, s + 2, exp);
          end
        end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rotate_left();
    test_right_shifts();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
